// File: rtl/chipselect_waitgen.sv
// Registered chip-select decoder and 68k bus-cycle sequencer (wait states, /DTACK, /BERR).
// Optional WAIT timeout to bus error is enabled by defining CS_BERR_TIMEOUT_EN.
module chipselect_waitgen #(
  parameter int ADDR_W      = 32,
  parameter int NUM_SELECTS = 8,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          as_n,
  input  logic [NUM_SELECTS-1:0]        region_en,
  input  logic [NUM_SELECTS*WAIT_W-1:0] wait_cfg,
  input  logic                          ext_wait,
  output logic [NUM_SELECTS-1:0]        cs_n,
  output logic                          dtack_n,
  output logic                          berr_n,
  output logic                          busy
);

  // state  | meaning
  // IDLE   | no bus cycle, waiting for as_n low
  // WAIT   | chip select low, counting wait states / honouring ext_wait
  // ACK    | chip select and /DTACK low until as_n rises
  // BERR   | /BERR low until as_n rises
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;

  localparam int SEL_W = $clog2(NUM_SELECTS);

  if (TIMEOUT <= (1 << WAIT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT must exceed the largest programmable wait count");
  end

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SELECTS-1:0]  cs_n_q, cs_n_d;
  logic                    dtack_n_q, dtack_n_d;
  logic                    berr_n_q, berr_n_d;
  logic                    busy_q, busy_d;
  logic                    timeout_hit;

  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-SEL_W-1:0];

`ifdef CS_BERR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != S_WAIT) tmo_d = '0;
    else                   tmo_d = tmo_q + 1'b1;
  end

  assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      cs_n_q    <= '1;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      cs_n_q    <= cs_n_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      busy_q    <= busy_d;
    end
  end

  // Abort (as_n high) wins over timeout, which wins over wait counting.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!as_n) begin
          sel_d = addr[ADDR_W-1 -: SEL_W];
          if (region_en[sel_d]) begin
            state_d = S_WAIT;
            cnt_d   = wait_cfg[sel_d*WAIT_W +: WAIT_W];
          end else begin
            state_d = S_BERR;
          end
        end
      end
      S_WAIT: begin
        if (as_n)                state_d = S_IDLE;
        else if (timeout_hit)    state_d = S_BERR;
        else if (cnt_q != '0)    cnt_d   = cnt_q - 1'b1;
        else if (!ext_wait)      state_d = S_ACK;
      end
      S_ACK, S_BERR: begin
        if (as_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    cs_n_d    = '1;
    dtack_n_d = 1'b1;
    berr_n_d  = 1'b1;
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_WAIT || state_d == S_ACK) cs_n_d[sel_d] = 1'b0;
    if (state_d == S_ACK)                      dtack_n_d     = 1'b0;
    if (state_d == S_BERR)                     berr_n_d      = 1'b0;
  end

  assign cs_n    = cs_n_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_chipselect_waitgen.sv
// Directed bench for chipselect_waitgen: vector table plus hand sequences for wait, abort, timeout, reset.
module tb_chipselect_waitgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        as_n;
  logic [7:0]  region_en;
  logic [31:0] wait_cfg;
  logic        ext_wait;
  logic [7:0]  cs_n;
  logic        dtack_n;
  logic        berr_n;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chipselect_waitgen #(
    .ADDR_W(32), .NUM_SELECTS(8), .WAIT_W(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .as_n(as_n),
    .region_en(region_en), .wait_cfg(wait_cfg), .ext_wait(ext_wait),
    .cs_n(cs_n), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
  );

  typedef struct {
    logic        as_n;
    logic [31:0] addr;
    logic [7:0]  ren;
    logic        ext;
    logic [7:0]  cs;
    logic        dt;
    logic        be;
    logic        bsy;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [7:0] ecs, input logic edt,
                       input logic ebe, input logic ebsy);
    n_vec++;
    if (cs_n !== ecs || dtack_n !== edt || berr_n !== ebe || busy !== ebsy) begin
      n_err++;
      $display("FAIL %s: got cs_n=%h dtack_n=%b berr_n=%b busy=%b, want cs_n=%h dtack_n=%b berr_n=%b busy=%b",
               name, cs_n, dtack_n, berr_n, busy, ecs, edt, ebe, ebsy);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // w7=5 w6=0 w5=1 w4=0 w3=0 w2=0 w1=10 w0=2
    wait_cfg  = 32'h5010_00A2;
    rst_n     = 1'b0;
    as_n      = 1'b1;
    addr      = '0;
    region_en = 8'hFF;
    ext_wait  = 1'b0;

    //          as_n  addr           ren    ext   cs     dt    be    busy
    vecs[0]  = '{1'b0, 32'h6000_0000, 8'hFF, 1'b0, 8'hF7, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 32'h6000_0000, 8'hFF, 1'b0, 8'hF7, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 32'h6000_0000, 8'hFF, 1'b0, 8'hF7, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 32'h6000_0000, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h4000_0000, 8'hFB, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'h4000_0000, 8'hFB, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h4000_0000, 8'hFB, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'hA000_0000, 8'hFF, 1'b0, 8'hDF, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'hDF, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'hDF, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0000, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0000, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 32'h0000_0000, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0000, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 32'h0000_0000, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};

    #12;
    check("reset", 8'hFF, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick;
    check("idle_after_reset", 8'hFF, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 17; i++) begin
      as_n      = vecs[i].as_n;
      addr      = vecs[i].addr;
      region_en = vecs[i].ren;
      ext_wait  = vecs[i].ext;
      tick;
      check($sformatf("vec%0d", i), vecs[i].cs, vecs[i].dt, vecs[i].be, vecs[i].bsy);
    end

    // Region 7, five wait states: /DTACK after edge 6.
    addr = 32'hE000_0000; region_en = 8'hFF; ext_wait = 1'b0; as_n = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick;
      check($sformatf("wait5_edge%0d", e), 8'h7F, (e >= 6) ? 1'b0 : 1'b1, 1'b1, 1'b1);
    end
    as_n = 1'b1;
    tick;
    check("wait5_release", 8'hFF, 1'b1, 1'b1, 1'b0);

    // Same region, ext_wait sampled high at edges 6..8: /DTACK after edge 9.
    ext_wait = 1'b1; as_n = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      tick;
      check($sformatf("extwait_edge%0d", e), 8'h7F, (e >= 9) ? 1'b0 : 1'b1, 1'b1, 1'b1);
      if (e == 8) ext_wait = 1'b0;
    end
    as_n = 1'b1;
    tick;
    check("extwait_release", 8'hFF, 1'b1, 1'b1, 1'b0);

    // Region 1, ten wait states, aborted by as_n high sampled at edge 4.
    addr = 32'h2000_0000; as_n = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      tick;
      check($sformatf("abort_edge%0d", e), 8'hFD, 1'b1, 1'b1, 1'b1);
    end
    as_n = 1'b1;
    for (int e = 4; e <= 16; e++) begin
      tick;
      check($sformatf("abort_after%0d", e), 8'hFF, 1'b1, 1'b1, 1'b0);
    end

    // ext_wait stuck high on region 7.
    addr = 32'hE000_0000; ext_wait = 1'b1; as_n = 1'b0;
`ifdef CS_BERR_TIMEOUT_EN
    for (int e = 0; e <= 20; e++) begin
      tick;
      if (e == 19)
        check("timeout_edge19", 8'h7F, 1'b1, 1'b1, 1'b1);
      else if (e == 20)
        check("timeout_edge20", 8'hFF, 1'b1, 1'b0, 1'b1);
    end
`else
    for (int e = 0; e <= 100; e++) begin
      tick;
      if (e == 20 || e == 100)
        check($sformatf("notimeout_edge%0d", e), 8'h7F, 1'b1, 1'b1, 1'b1);
    end
`endif
    as_n = 1'b1; ext_wait = 1'b0;
    tick;
    check("stuck_release", 8'hFF, 1'b1, 1'b1, 1'b0);

    // Async reset in the middle of a WAIT.
    addr = 32'hE000_0000; as_n = 1'b0;
    tick;
    check("pre_reset_wait", 8'h7F, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 8'hFF, 1'b1, 1'b1, 1'b0);
    as_n = 1'b1;
    #2 rst_n = 1'b1;
    tick;
    check("post_reset_idle", 8'hFF, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
